// File: rtl/mnist_pkg.sv
// Shared constants for the MNIST batch scheduler: image geometry, address/index
// widths and the sequencing state encoding.
package mnist_pkg;
  localparam int PIX      = 784;
  localparam int IMG_BITS = PIX * 8;
  localparam int ADDR_W   = 14;
  localparam int IDX_W    = 5;

  typedef logic [2:0] state_t;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LOAD   = 3'd1;
  localparam logic [2:0] S_LTAIL  = 3'd2;
  localparam logic [2:0] S_START  = 3'd3;
  localparam logic [2:0] S_WAIT   = 3'd4;
  localparam logic [2:0] S_RECORD = 3'd5;
  localparam logic [2:0] S_NEXT   = 3'd6;
  localparam logic [2:0] S_FIN    = 3'd7;
endpackage

// File: rtl/mnist_img_loader.sv
// Streams one image from the byte-wide ROM into the wide pixel register.
// ROM data lags the read strobe by one cycle, so writes use a delayed pointer.
module mnist_img_loader
  import mnist_pkg::*;
#(
  parameter int N_PIX = PIX
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load_go,
  input  logic [ADDR_W-1:0]     base_addr,
  output logic                  rd_en,
  output logic [ADDR_W-1:0]     rd_addr,
  input  logic [7:0]            rd_data,
  output logic                  load_done,
  output logic [N_PIX*8-1:0]    img_data
);
  localparam int PW = $clog2(N_PIX);

  logic          active_q, active_d;
  logic [PW-1:0] pix_q, pix_d;
  logic          wr_en_q;
  logic [PW-1:0] wr_ptr_q;
  logic [N_PIX*8-1:0] img_q;

  always_comb begin
    active_d = active_q;
    pix_d    = pix_q;
    if (load_go) begin
      active_d = 1'b1;
      pix_d    = '0;
    end else if (active_q) begin
      if (pix_q == PW'(N_PIX - 1)) active_d = 1'b0;
      else                         pix_d    = pix_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active_q <= 1'b0;
      pix_q    <= '0;
      wr_en_q  <= 1'b0;
      wr_ptr_q <= '0;
      img_q    <= '0;
    end else begin
      active_q <= active_d;
      pix_q    <= pix_d;
      wr_en_q  <= active_q;
      wr_ptr_q <= pix_q;
      if (wr_en_q) img_q[{wr_ptr_q, 3'b000} +: 8] <= rd_data;
    end
  end

  assign rd_en     = active_q;
  assign rd_addr   = base_addr + ADDR_W'(pix_q);
  assign load_done = active_q && (pix_q == PW'(N_PIX - 1));
  assign img_data  = img_q;
endmodule

// File: rtl/mnist_batch_sched.sv
// Batch sequencer: load image, start the accelerator, wait for a fresh done edge,
// score the prediction against the label ROM, repeat for the requested count.
module mnist_batch_sched #(
  parameter int MAX_IMGS = 20,
  parameter int PIX      = 784,
  parameter int TIMEOUT  = 65535
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              go,
  input  logic [4:0]        batch_len,
  output logic              img_rd_en,
  output logic [13:0]       img_rd_addr,
  input  logic [7:0]        img_rd_data,
  output logic [4:0]        lbl_rd_addr,
  input  logic [3:0]        lbl_rd_data,
  output logic              acc_start,
  output logic [PIX*8-1:0]  acc_img_data,
  input  logic [3:0]        acc_pred,
  input  logic              acc_done,
  output logic              busy,
  output logic              res_valid,
  output logic [4:0]        res_idx,
  output logic [3:0]        res_pred,
  output logic              res_match,
  output logic [4:0]        correct_cnt,
  output logic              batch_done,
  output logic              timeout_err
);
  import mnist_pkg::*;

  state_t            state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d, len_q, len_d, cnt_q, cnt_d;
  logic [IDX_W-1:0]  len_in, idx_inc;
  logic              terr_q, terr_d, done_prev_q, done_prev_d;
  logic [15:0]       wcnt_q, wcnt_d;
  logic [3:0]        lbl_q, lbl_d, pred_q, pred_d;
  logic              load_go, load_done;
  logic [ADDR_W-1:0] base_addr;

  assign len_in    = (int'(batch_len) > MAX_IMGS) ? IDX_W'(MAX_IMGS) : batch_len;
  assign idx_inc   = idx_q + 1'b1;
  assign base_addr = ADDR_W'(idx_q) * ADDR_W'(PIX);

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    len_d       = len_q;
    cnt_d       = cnt_q;
    terr_d      = terr_q;
    done_prev_d = done_prev_q;
    wcnt_d      = wcnt_q;
    lbl_d       = lbl_q;
    pred_d      = pred_q;
    load_go     = 1'b0;
    case (state_q)
      S_IDLE: if (go) begin
        len_d  = len_in;
        cnt_d  = '0;
        terr_d = 1'b0;
        idx_d  = '0;
        if (len_in == '0) state_d = S_FIN;
        else begin
          state_d = S_LOAD;
          load_go = 1'b1;
        end
      end
      S_LOAD:  if (load_done) state_d = S_LTAIL;
      S_LTAIL: begin
        lbl_d   = lbl_rd_data;
        state_d = S_START;
      end
      S_START: begin
        wcnt_d      = '0;
        done_prev_d = acc_done;
        state_d     = S_WAIT;
      end
      // Only a rising edge counts, so a done level left over from before start is ignored.
      S_WAIT: begin
        done_prev_d = acc_done;
        if (acc_done && !done_prev_q) begin
          pred_d  = acc_pred;
          state_d = S_RECORD;
        end else if (wcnt_q == 16'(TIMEOUT)) begin
          terr_d  = 1'b1;
          state_d = S_FIN;
        end else begin
          wcnt_d = wcnt_q + 1'b1;
        end
      end
      S_RECORD: begin
        if (pred_q == lbl_q) cnt_d = cnt_q + 1'b1;
        state_d = S_NEXT;
      end
      S_NEXT: begin
        idx_d = idx_inc;
        if (idx_inc == len_q) state_d = S_FIN;
        else begin
          state_d = S_LOAD;
          load_go = 1'b1;
        end
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      len_q       <= '0;
      cnt_q       <= '0;
      terr_q      <= 1'b0;
      done_prev_q <= 1'b0;
      wcnt_q      <= '0;
      lbl_q       <= '0;
      pred_q      <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      len_q       <= len_d;
      cnt_q       <= cnt_d;
      terr_q      <= terr_d;
      done_prev_q <= done_prev_d;
      wcnt_q      <= wcnt_d;
      lbl_q       <= lbl_d;
      pred_q      <= pred_d;
    end
  end

  mnist_img_loader #(.N_PIX(PIX)) u_loader (
    .clk       (clk),
    .rst_n     (rst_n),
    .load_go   (load_go),
    .base_addr (base_addr),
    .rd_en     (img_rd_en),
    .rd_addr   (img_rd_addr),
    .rd_data   (img_rd_data),
    .load_done (load_done),
    .img_data  (acc_img_data)
  );

  // Result fields are gated so every output reads zero outside RECORD and in reset.
  assign lbl_rd_addr = idx_q;
  assign acc_start   = (state_q == S_START);
  assign busy        = (state_q != S_IDLE) && (state_q != S_FIN);
  assign batch_done  = (state_q == S_FIN);
  assign res_valid   = (state_q == S_RECORD);
  assign res_idx     = res_valid ? idx_q : '0;
  assign res_pred    = res_valid ? pred_q : '0;
  assign res_match   = res_valid && (pred_q == lbl_q);
  assign correct_cnt = cnt_q;
  assign timeout_err = terr_q;
endmodule

// File: doc/mnist_batch_sched.md
Name: mnist_batch_sched

Overview:
- Batch controller that sequences the mnist_accel inference core over a stored test set.
- For each image it does four things in order:
  - streams 784 pixel bytes from an external image ROM into a 6272-bit vector;
  - pulses the core's start;
  - waits for the core's done;
  - compares the prediction with the label ROM and logs the result.
- Sits between the image/label memories and mnist_accel, replacing bench-driven sequencing for on-chip batch accuracy runs.

Parameters:
- MAX_IMGS, 20, maximum images per batch; sets index and count widths.
- PIX, 784, pixels per image.
- TIMEOUT, 65535, maximum cycles in WAIT before the batch aborts.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- go  in  1  one-cycle batch start request; ignored while busy=1.
- batch_len  in  5  number of images to run; 0 is legal; values >MAX_IMGS clamp to MAX_IMGS.
- img_rd_en  out  1  image ROM read strobe.
- img_rd_addr  out  14  byte address = idx*PIX + pixel.
- img_rd_data  in  8  ROM data, valid exactly 1 cycle after img_rd_en.
- lbl_rd_addr  out  5  label ROM address (= idx).
- lbl_rd_data  in  4  label, valid 1 cycle after lbl_rd_addr changes.
- acc_start  out  1  one-cycle start pulse to mnist_accel.
- acc_img_data  out  6272  pixel vector; pixel k occupies bits [k*8+:8]; held stable from acc_start until done.
- acc_pred  in  4  predicted digit.
- acc_done  in  1  done from mnist_accel (level or pulse).
- busy  out  1  high from the cycle after an accepted go until FIN.
- res_valid  out  1  one-cycle per-image result strobe.
- res_idx  out  5  image index of the result.
- res_pred  out  4  captured acc_pred.
- res_match  out  1  res_pred == label.
- correct_cnt  out  5  running count of matches in the current batch.
- batch_done  out  1  one-cycle end-of-batch pulse.
- timeout_err  out  1  sticky abort flag; cleared on the next accepted go.

Behaviour:
- Reset (async, rst_n=0):
  - all outputs, state, counters and acc_img_data are 0; state=IDLE.
  - Reset mid-batch drops acc_start immediately and the batch is discarded.
- IDLE:
  - go=1 latches the clamped batch_len as len, clears correct_cnt, timeout_err and idx.
  - Goes to FIN if len=0, else to LOAD.
- LOAD:
  - PIX cycles, img_rd_en=1, img_rd_addr = idx*PIX + p for p=0..783.
  - Data captured into byte p one cycle later; lbl_rd_addr=idx held throughout.
  - After p=783 goes to LTAIL.
- LTAIL: one cycle that captures the last byte and the label into lbl_q, then goes to START.
- START:
  - acc_start=1 for exactly one cycle.
  - Clears the WAIT counter and samples done_prev=acc_done.
  - Goes to WAIT.
- WAIT:
  - Completion is a rising edge (acc_done=1 && done_prev=0), which prevents a stale done level being taken.
  - On completion, captures acc_pred and goes to RECORD.
  - Counter at TIMEOUT sets timeout_err=1 and goes to FIN with no res_valid for that image.
- RECORD:
  - res_valid=1, res_idx=idx, res_pred, res_match=(pred==lbl_q).
  - correct_cnt increments on match, in the same cycle, visible the next cycle.
  - Goes to NEXT.
- NEXT: idx+1; goes to FIN if idx+1==len, else to LOAD.
- FIN:
  - batch_done=1 for one cycle; busy=0 from this cycle.
  - Goes to IDLE.
  - correct_cnt and timeout_err hold until the next accepted go.
- Latency per image: PIX+1 (load) + 1 (start) + accel time + 1 edge-detect + 2 (record/next).
- go in any non-IDLE state: ignored, no effect.
- go coincident with FIN: ignored; it is accepted only in IDLE.
- Address arithmetic is 14-bit unsigned; max address is 19*784+783 = 15679, no wrap.

Decomposition:
- Shared package mnist_pkg holds:
  - PIX=784, IMG_BITS=6272, ADDR_W=14, IDX_W=5;
  - state enum IDLE/LOAD/LTAIL/START/WAIT/RECORD/NEXT/FIN.
- One sub-module, mnist_img_loader:
  - owns the pixel counter, the ROM read strobe and addressing, and the delayed-write byte capture into the 6272-bit register;
  - has a load_go/load_done handshake.

Test Plan:
- Reset then go with batch_len=5, five images with labels 6,2,3,7,2, using an accel model that returns the label after 50 cycles:
  - 5 res_valid pulses, idx 0..4, all res_match=1;
  - correct_cnt=5, one batch_done pulse.
- Same batch with the model returning 0 for idx 1 and 3 -> res_match pattern 1,0,1,0,1; correct_cnt=3.
- Address check on image 2:
  - img_rd_addr runs 1568..2351 contiguous, with img_rd_en high for 784 cycles;
  - acc_img_data[7:0] equals ROM[1568] at acc_start.
- batch_len=0 -> batch_done 2 cycles after go, no img_rd_en, correct_cnt=0.
- batch_len=25 -> exactly 20 results.
- Model holds acc_done=1 from before start and never toggles; TIMEOUT=100 -> timeout_err=1, batch_done, no res_valid for that image.
- go pulsed mid-WAIT -> no effect.
- rst_n=0 during LOAD -> all outputs 0 the same cycle; new go after release runs cleanly from idx 0.
